// File: rtl/patp_pkg.sv
// rtl/patp_pkg.sv - opcode, ALU function and state definitions shared by the PATP sequencer
package patp_pkg;

  // Instruction opcodes; anything above OP_STORE is illegal
  localparam int unsigned OP_CLEAR = 32'd0;
  localparam int unsigned OP_INC1  = 32'd1;
  localparam int unsigned OP_ADD   = 32'd2;
  localparam int unsigned OP_DEC1  = 32'd3;
  localparam int unsigned OP_JMP   = 32'd4;
  localparam int unsigned OP_BUZ   = 32'd5;
  localparam int unsigned OP_LOAD  = 32'd6;
  localparam int unsigned OP_STORE = 32'd7;

  typedef enum logic [1:0] {
    FUNC_CLR = 2'd0,
    FUNC_INC = 2'd1,
    FUNC_ADD = 2'd2,
    FUNC_DEC = 2'd3
  } func_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F1   = 3'd1,
    S_F2   = 3'd2,
    S_F3   = 3'd3,
    S_F4   = 3'd4,
    S_E1   = 3'd5,
    S_E2   = 3'd6,
    S_E3   = 3'd7
  } state_t;

  // Width of the D-register select field; never narrower than one bit
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/patp_sequencer_if.sv
// rtl/patp_sequencer_if.sv - control/status bundle between the PATP sequencer and its datapath
interface patp_sequencer_if #(
  parameter int NUM_DREGS = 1,
  parameter int OPCODE_W  = 3
) ();
  localparam int SEL_W = patp_pkg::sel_width(NUM_DREGS);

  logic                 run;
  logic [OPCODE_W-1:0]  ir_opcode;
  logic [SEL_W-1:0]     ir_sel;
  logic                 z;
  logic                 mem_ready;

  logic                 oe_ms;
  logic                 oe_ir;
  logic                 oe_pc;
  logic                 oe_alureg;
  logic [NUM_DREGS-1:0] oe_d;
  logic                 we_mar;
  logic                 we_ir;
  logic                 we_pc;
  logic                 we_alureg;
  logic [NUM_DREGS-1:0] we_d;
  logic [1:0]           func;
  logic                 read;
  logic                 write;
  logic                 start_fetch;
  logic                 start_execute;
  logic                 busy;
  logic                 illegal_op;

  modport master (
    input  run, ir_opcode, ir_sel, z, mem_ready,
    output oe_ms, oe_ir, oe_pc, oe_alureg, oe_d,
    output we_mar, we_ir, we_pc, we_alureg, we_d,
    output func, read, write,
    output start_fetch, start_execute, busy, illegal_op
  );

  modport slave (
    output run, ir_opcode, ir_sel, z, mem_ready,
    input  oe_ms, oe_ir, oe_pc, oe_alureg, oe_d,
    input  we_mar, we_ir, we_pc, we_alureg, we_d,
    input  func, read, write,
    input  start_fetch, start_execute, busy, illegal_op
  );
endinterface

// File: rtl/patp_ctrl_decode.sv
// rtl/patp_ctrl_decode.sv - per-state control decode; PATP_WAIT_STATE_EN adds memory wait states
module patp_ctrl_decode
  import patp_pkg::*;
#(
  parameter int NUM_DREGS = 1,
  parameter int OPCODE_W  = 3,
  parameter int SEL_W     = 1
) (
  input  state_t               state,
  input  logic [OPCODE_W-1:0]  op_q,
  input  logic [SEL_W-1:0]     sel_q,
  input  logic                 z,
  input  logic                 mem_ready,
  output logic                 oe_ms,
  output logic                 oe_ir,
  output logic                 oe_pc,
  output logic                 oe_alureg,
  output logic [NUM_DREGS-1:0] oe_d,
  output logic                 we_mar,
  output logic                 we_ir,
  output logic                 we_pc,
  output logic                 we_alureg,
  output logic [NUM_DREGS-1:0] we_d,
  output logic [1:0]           func,
  output logic                 read,
  output logic                 write,
  output logic                 start_fetch,
  output logic                 start_execute,
  output logic                 busy,
  output logic                 illegal_op,
  output logic                 stall,
  output logic                 last
);

  logic                 mem_done;
  logic [31:0]          op_ext;
  logic                 op_illegal;
  logic [NUM_DREGS-1:0] d_sel;

`ifdef PATP_WAIT_STATE_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done = 1'b1;
`endif

  assign op_ext     = 32'(op_q);
  assign op_illegal = (op_ext > OP_STORE);

  // One-hot register select; a select beyond the last register matches nothing
  always_comb begin
    d_sel = '0;
    for (int i = 0; i < NUM_DREGS; i++) begin
      d_sel[i] = (sel_q == SEL_W'(i));
    end
  end

  // Output decode: memory states hold strobes while waiting and gate write enables on completion
  always_comb begin
    oe_ms = 1'b0; oe_ir = 1'b0; oe_pc = 1'b0; oe_alureg = 1'b0; oe_d = '0;
    we_mar = 1'b0; we_ir = 1'b0; we_pc = 1'b0; we_alureg = 1'b0; we_d = '0;
    func = FUNC_CLR; read = 1'b0; write = 1'b0;
    start_execute = 1'b0; illegal_op = 1'b0;
    stall = 1'b0; last = 1'b0;
    busy = (state != S_IDLE);
    case (state)
      S_F1: begin
        oe_pc = 1'b1; we_mar = 1'b1;
      end
      S_F2: begin
        read = 1'b1; oe_ms = 1'b1; we_ir = mem_done; stall = !mem_done;
      end
      S_F3: begin
        oe_pc = 1'b1; func = FUNC_INC; we_alureg = 1'b1;
      end
      S_F4: begin
        oe_alureg = 1'b1; we_pc = 1'b1; start_execute = 1'b1;
      end
      S_E1: begin
        if (op_illegal) begin
          illegal_op = 1'b1; last = 1'b1;
        end else begin
          case (op_ext)
            OP_CLEAR: begin func = FUNC_CLR; we_alureg = 1'b1; end
            OP_INC1:  begin oe_d = d_sel; func = FUNC_INC; we_alureg = 1'b1; end
            OP_DEC1:  begin oe_d = d_sel; func = FUNC_DEC; we_alureg = 1'b1; end
            OP_ADD, OP_LOAD, OP_STORE: begin oe_ir = 1'b1; we_mar = 1'b1; end
            OP_JMP:   begin oe_ir = 1'b1; we_pc = 1'b1; last = 1'b1; end
            OP_BUZ:   begin oe_ir = z; we_pc = z; last = 1'b1; end
            default:  ;
          endcase
        end
      end
      S_E2: begin
        case (op_ext)
          OP_CLEAR, OP_INC1, OP_DEC1: begin
            oe_alureg = 1'b1; we_d = d_sel; last = 1'b1;
          end
          OP_ADD: begin
            read = 1'b1; oe_ms = 1'b1; func = FUNC_ADD;
            we_alureg = mem_done; stall = !mem_done;
          end
          OP_LOAD: begin
            read = 1'b1; oe_ms = 1'b1;
            we_d = mem_done ? d_sel : '0; stall = !mem_done; last = 1'b1;
          end
          OP_STORE: begin
            write = 1'b1; oe_d = d_sel; stall = !mem_done; last = 1'b1;
          end
          default: ;
        endcase
      end
      S_E3: begin
        if (op_ext == OP_ADD) begin
          oe_alureg = 1'b1; we_d = d_sel; last = 1'b1;
        end
      end
      default: ;
    endcase
    start_fetch = last && !stall;
  end

endmodule

// File: rtl/patp_sequencer.sv
// rtl/patp_sequencer.sv - PATP fetch/execute sequencer top; PATP_WAIT_STATE_EN enables memory wait states
module patp_sequencer
  import patp_pkg::*;
#(
  parameter int NUM_DREGS = 1,
  parameter int OPCODE_W  = 3
) (
  input logic               clk,
  input logic               rst_n,
  patp_sequencer_if.master  bus
);

  localparam int SEL_W = sel_width(NUM_DREGS);

  state_t              state;
  state_t              state_nx;
  logic [OPCODE_W-1:0] op_q;
  logic [SEL_W-1:0]    sel_q;
  logic                stall;
  logic                last;

  // State register plus IR capture as F4 hands over to execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
      sel_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_F4) begin
        op_q  <= bus.ir_opcode;
        sel_q <= bus.ir_sel;
      end
    end
  end

  // Next state: fetch runs straight through, execute ends when the decode flags its last cycle
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.run) state_nx = S_F1;
      S_F1:   state_nx = S_F2;
      S_F2:   if (!stall) state_nx = S_F3;
      S_F3:   state_nx = S_F4;
      S_F4:   state_nx = S_E1;
      S_E1, S_E2, S_E3: begin
        if (stall)            state_nx = state;
        else if (last)        state_nx = bus.run ? S_F1 : S_IDLE;
        else if (state == S_E1) state_nx = S_E2;
        else                  state_nx = S_E3;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  patp_ctrl_decode #(
    .NUM_DREGS (NUM_DREGS),
    .OPCODE_W  (OPCODE_W),
    .SEL_W     (SEL_W)
  ) u_decode (
    .state         (state),
    .op_q          (op_q),
    .sel_q         (sel_q),
    .z             (bus.z),
    .mem_ready     (bus.mem_ready),
    .oe_ms         (bus.oe_ms),
    .oe_ir         (bus.oe_ir),
    .oe_pc         (bus.oe_pc),
    .oe_alureg     (bus.oe_alureg),
    .oe_d          (bus.oe_d),
    .we_mar        (bus.we_mar),
    .we_ir         (bus.we_ir),
    .we_pc         (bus.we_pc),
    .we_alureg     (bus.we_alureg),
    .we_d          (bus.we_d),
    .func          (bus.func),
    .read          (bus.read),
    .write         (bus.write),
    .start_fetch   (bus.start_fetch),
    .start_execute (bus.start_execute),
    .busy          (bus.busy),
    .illegal_op    (bus.illegal_op),
    .stall         (stall),
    .last          (last)
  );

endmodule

// File: tb/tb_patp_sequencer.sv
// tb/tb_patp_sequencer.sv - directed self-checking bench for patp_sequencer
module tb_patp_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  patp_sequencer_if #(.NUM_DREGS(4), .OPCODE_W(4)) sif ();
  patp_sequencer_if #(.NUM_DREGS(3), .OPCODE_W(3)) sif3 ();

  patp_sequencer #(.NUM_DREGS(4), .OPCODE_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(sif.master)
  );
  patp_sequencer #(.NUM_DREGS(3), .OPCODE_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(sif3.master)
  );

  assign sif3.run       = sif.run;
  assign sif3.ir_opcode = sif.ir_opcode[2:0];
  assign sif3.ir_sel    = sif.ir_sel;
  assign sif3.z         = sif.z;
  assign sif3.mem_ready = sif.mem_ready;

  always #5 clk = ~clk;

  logic [23:0] obs;
  assign obs = {sif.oe_ms, sif.oe_ir, sif.oe_pc, sif.oe_alureg, sif.oe_d,
                sif.we_mar, sif.we_ir, sif.we_pc, sif.we_alureg, sif.we_d,
                sif.func, sif.read, sif.write,
                sif.start_fetch, sif.start_execute, sif.busy, sif.illegal_op};

  localparam logic [23:0] OE_MS  = 24'h800000;
  localparam logic [23:0] OE_IR  = 24'h400000;
  localparam logic [23:0] OE_PC  = 24'h200000;
  localparam logic [23:0] OE_ALU = 24'h100000;
  localparam logic [23:0] WE_MAR = 24'h008000;
  localparam logic [23:0] WE_IR  = 24'h004000;
  localparam logic [23:0] WE_PC  = 24'h002000;
  localparam logic [23:0] WE_ALU = 24'h001000;
  localparam logic [23:0] READ   = 24'h000020;
  localparam logic [23:0] WRITE  = 24'h000010;
  localparam logic [23:0] SF     = 24'h000008;
  localparam logic [23:0] SE     = 24'h000004;
  localparam logic [23:0] BUSY   = 24'h000002;
  localparam logic [23:0] ILL    = 24'h000001;

  function automatic logic [23:0] oed(input logic [3:0] n);
    return {4'b0, n, 16'b0};
  endfunction
  function automatic logic [23:0] wed(input logic [3:0] n);
    return {12'b0, n, 8'b0};
  endfunction
  function automatic logic [23:0] fn(input logic [1:0] f);
    return {16'b0, f, 6'b0};
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input string tag, input logic [23:0] exp);
    @(negedge clk);
    check(tag, obs, exp);
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_f1"}, OE_PC | WE_MAR | BUSY);
    cyc({tag, "_f2"}, READ | OE_MS | WE_IR | BUSY);
    cyc({tag, "_f3"}, OE_PC | fn(2'd1) | WE_ALU | BUSY);
    cyc({tag, "_f4"}, OE_ALU | WE_PC | SE | BUSY);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    sif.run = 1'b0; sif.ir_opcode = '0; sif.ir_sel = '0; sif.z = 1'b0; sif.mem_ready = 1'b1;
    cyc("reset", 24'h0);
    rst_n = 1'b1;
    cyc("idle_run0", 24'h0);

    sif.ir_opcode = 4'd6; sif.ir_sel = 2'd2; sif.run = 1'b1;
    fetch("load");
    cyc("load_e1", OE_IR | WE_MAR | BUSY);
    cyc("load_e2", READ | OE_MS | wed(4'b0100) | SF | BUSY);

    sif.ir_opcode = 4'd1; sif.ir_sel = 2'd3;
    fetch("inc");
    cyc("inc_e1", oed(4'b1000) | fn(2'd1) | WE_ALU | BUSY);
    check("oob_oe", {20'b0, sif3.oe_d, sif3.we_alureg}, 24'h1);
    cyc("inc_e2", OE_ALU | wed(4'b1000) | SF | BUSY);
    check("oob_we", {20'b0, sif3.we_d, sif3.oe_alureg}, 24'h1);

    sif.ir_opcode = 4'd3; sif.ir_sel = 2'd0;
    fetch("dec");
    cyc("dec_e1", oed(4'b0001) | fn(2'd3) | WE_ALU | BUSY);
    cyc("dec_e2", OE_ALU | wed(4'b0001) | SF | BUSY);

    sif.ir_opcode = 4'd0; sif.ir_sel = 2'd1;
    fetch("clr");
    cyc("clr_e1", fn(2'd0) | WE_ALU | BUSY);
    cyc("clr_e2", OE_ALU | wed(4'b0010) | SF | BUSY);

    sif.ir_opcode = 4'd4;
    fetch("jmp");
    cyc("jmp_e1", OE_IR | WE_PC | SF | BUSY);

    sif.ir_opcode = 4'd5; sif.z = 1'b1;
    fetch("buz1");
    cyc("buz1_e1", OE_IR | WE_PC | SF | BUSY);
    sif.z = 1'b0;
    fetch("buz0");
    cyc("buz0_e1", SF | BUSY);

    sif.ir_opcode = 4'd7; sif.ir_sel = 2'd1;
    fetch("st");
`ifdef PATP_WAIT_STATE_EN
    sif.mem_ready = 1'b1;
`else
    sif.mem_ready = 1'b0;
`endif
    cyc("st_e1", OE_IR | WE_MAR | BUSY);
    cyc("st_e2", WRITE | oed(4'b0010) | SF | BUSY);
    sif.mem_ready = 1'b1;

`ifdef PATP_WAIT_STATE_EN
    sif.ir_opcode = 4'd6; sif.ir_sel = 2'd2;
    fetch("ws");
    cyc("ws_e1", OE_IR | WE_MAR | BUSY);
    sif.mem_ready = 1'b0;
    cyc("ws_hold1", READ | OE_MS | BUSY);
    cyc("ws_hold2", READ | OE_MS | BUSY);
    sif.mem_ready = 1'b1;
    #1 check("ws_done", obs, READ | OE_MS | wed(4'b0100) | SF | BUSY);
`endif

    sif.ir_opcode = 4'd2; sif.ir_sel = 2'd3;
    fetch("add");
    cyc("add_e1", OE_IR | WE_MAR | BUSY);
    sif.run = 1'b0;
    cyc("add_e2", READ | OE_MS | fn(2'd2) | WE_ALU | BUSY);
    cyc("add_e3", OE_ALU | wed(4'b1000) | SF | BUSY);
    cyc("add_idle", 24'h0);
    cyc("add_idle2", 24'h0);

    sif.ir_opcode = 4'hA; sif.ir_sel = 2'd0; sif.run = 1'b1;
    fetch("ill");
    cyc("ill_e1", SF | BUSY | ILL);

    sif.ir_opcode = 4'd7; sif.ir_sel = 2'd1;
    fetch("st2");
    cyc("st2_e1", OE_IR | WE_MAR | BUSY);
    cyc("st2_e2", WRITE | oed(4'b0010) | SF | BUSY);
    #1 rst_n = 1'b0;
    #1 check("rst_async", obs, 24'h0);
    cyc("rst_hold", 24'h0);
    rst_n = 1'b1;
    cyc("first_f1", OE_PC | WE_MAR | BUSY);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/patp_sequencer.md
PATP_SEQUENCER -- requirements
Module: patp_sequencer

Interface
REQ-001 SHALL have parameter NUM_DREGS, default 1, number of data registers D0..D(NUM_DREGS-1), legal range 1..8.
REQ-002 SHALL have parameter OPCODE_W, default 3, opcode width, minimum 3.
REQ-003 SHALL derive localparam SEL_W = max(1, clog2(NUM_DREGS)).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 run  in  1  level; permits starting a new instruction.
REQ-007 ir_opcode  in  OPCODE_W  opcode field of IR; valid from state F3.
REQ-008 ir_sel  in  SEL_W  D-register select field of IR; valid from state F3.
REQ-009 z  in  1  ALU zero flag.
REQ-010 mem_ready  in  1  memory completes the current read or write this cycle.
REQ-011 oe_ms, oe_ir, oe_pc, oe_alureg  out  1 each  bus drive enables.
REQ-012 oe_d  out  NUM_DREGS  one-hot D-register bus drive.
REQ-013 we_mar, we_ir, we_pc, we_alureg  out  1 each  register write enables.
REQ-014 we_d  out  NUM_DREGS  one-hot D-register write enable.
REQ-015 func  out  2  ALU op: 0 CLR, 1 INC, 2 ADD, 3 DEC.
REQ-016 read, write  out  1 each  memory strobes.
REQ-017 start_fetch, start_execute, busy, illegal_op  out  1 each  status signals.

Function
REQ-018 SHALL implement states IDLE, F1, F2, F3, F4, E1, E2, E3.
REQ-019 Every output not asserted by REQ-020..REQ-026 SHALL be 0 in that cycle.
REQ-020 Fetch SHALL drive: F1 oe_pc+we_mar; F2 read+oe_ms+we_ir; F3 oe_pc+func=INC+we_alureg; F4 oe_alureg+we_pc+start_execute.
REQ-021 On leaving F4, SHALL latch ir_opcode into op_q and ir_sel into sel_q; execute-state decode SHALL use only op_q and sel_q.
REQ-022 Opcodes SHALL be: 0 CLEAR, 1 INC1, 2 ADD, 3 DEC1, 4 JMP, 5 BUZ, 6 LOAD, 7 STORE.
REQ-023 Execute SHALL drive (D = bit sel_q):
- CLEAR: E1 func=CLR+we_alureg; E2 oe_alureg+we_d[D].
- INC1/DEC1: E1 oe_d[D]+func=INC/DEC+we_alureg; E2 oe_alureg+we_d[D].
- ADD: E1 oe_ir+we_mar; E2 read+oe_ms+func=ADD+we_alureg; E3 oe_alureg+we_d[D].
- LOAD: E1 oe_ir+we_mar; E2 read+oe_ms+we_d[D].
- STORE: E1 oe_ir+we_mar; E2 write+oe_d[D].
- JMP: E1 oe_ir+we_pc.
- BUZ: E1 oe_ir+we_pc if z=1; nothing if z=0.
REQ-024 Opcodes of 8 and above SHALL execute E1 only with no enables, and SHALL pulse illegal_op for one cycle in E1.
REQ-025 start_fetch SHALL be 1 in the final execute cycle.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Transitions:
- IDLE->F1 when run=1.
- F1->F2->F3->F4->E1.
- From the last execute state: ->F1 if run=1, else ->IDLE.
REQ-028 run=0 mid-instruction SHALL NOT abort; the instruction SHALL complete.
REQ-029 Any sel_q >= NUM_DREGS SHALL produce all-zero oe_d and we_d.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, op_q=0, sel_q=0, and all outputs 0, including mid-instruction and mid-memory-access.
REQ-031 After rst_n deasserts, the first F1 SHALL occur on the first clock edge with run=1.

Configuration
REQ-032 Macro PATP_WAIT_STATE_EN defined: in memory states (F2, ADD E2, LOAD E2, STORE E2), read/write and oe_* SHALL hold while mem_ready=0. The state SHALL NOT advance, and we_* and start_* SHALL assert only in the cycle mem_ready=1.
REQ-033 Macro PATP_WAIT_STATE_EN undefined: mem_ready SHALL be ignored and every state SHALL last exactly one cycle.

Structure
REQ-034 Package patp_pkg SHALL hold the opcode constants, the func constants, and the state enum.
REQ-035 Combinational output decode SHALL live in sub-module patp_ctrl_decode (inputs: state, op_q, sel_q, z, mem_ready). The state register and next-state logic SHALL stay in patp_sequencer.

Verification
REQ-036 NUM_DREGS=4, run=1, LOAD sel=2, mem_ready=1 -> 6 cycles total; we_d=4'b0100 in E2 only.
REQ-037 PATP_WAIT_STATE_EN, LOAD sel=2, mem_ready=0 for 2 cycles in E2 -> read held 3 cycles; we_d=4'b0100 only in the 3rd; start_fetch coincident with it.
REQ-038 BUZ with z=1 -> we_pc=1 in E1; BUZ with z=0 -> all enables 0 in E1; both followed by F1.
REQ-039 ADD, run dropped in E1 -> E2 and E3 complete, we_d asserted in E3, then IDLE with busy=0.
REQ-040 OPCODE_W=4, opcode 4'hA -> one E1 cycle with illegal_op=1 and all enables 0; rst_n pulsed low in STORE E2 -> write=0 immediately and state IDLE.
